// File: rtl/winograd_pkg.sv
// ---------------------------------------------------------------------------
// winograd_pkg
// Shared constants for the Winograd F(2x2,3x3) blocks (filter transform,
// input transform, output transform).
//   TILE_IN / TILE_OUT : tile edge lengths (4x4 in, 2x2 out)
//   AT_COEF            : A^T = [1 1 1 0; 0 1 -1 -1]
//   elem_in_msb        : MSB of element (r,c) in a packed 4x4 tile, (0,0) on top
//   elem_out_msb       : MSB of element (i,j) in a packed 2x2 tile, (0,0) on top
// ---------------------------------------------------------------------------
package winograd_pkg;

  localparam int TILE_IN  = 4;
  localparam int TILE_OUT = 2;

  localparam int AT_COEF [TILE_OUT][TILE_IN] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  function automatic int elem_in_msb(input int r, input int c, input int w);
    return (TILE_IN * TILE_IN - (r * TILE_IN + c)) * w - 1;
  endfunction

  function automatic int elem_out_msb(input int i, input int j, input int w);
    return (TILE_OUT * TILE_OUT - (i * TILE_OUT + j)) * w - 1;
  endfunction

endpackage

// File: rtl/winograd_output_transform_if.sv
// ---------------------------------------------------------------------------
// winograd_output_transform_if
// Valid/ready bundle around the output transform.
//   in_valid/in_ready/in_tile    : 4x4 product tile M, 16 x IW bits
//   out_valid/out_ready/out_tile : 2x2 result tile Y, 4 x (IW+4) bits
// Modports: slave = the transform block, master = whoever drives it.
// ---------------------------------------------------------------------------
interface winograd_output_transform_if #(
  parameter int IW = 8
);
  localparam int OW = IW + 4;

  logic              in_valid;
  logic              in_ready;
  logic [16*IW-1:0]  in_tile;
  logic              out_valid;
  logic              out_ready;
  logic [4*OW-1:0]   out_tile;

  modport slave (
    input  in_valid, in_tile, out_ready,
    output in_ready, out_valid, out_tile
  );

  modport master (
    output in_valid, in_tile, out_ready,
    input  in_ready, out_valid, out_tile
  );

endinterface

// File: rtl/winograd_at_1d.sv
// ---------------------------------------------------------------------------
// winograd_at_1d
// One-dimensional A^T product on a 4-vector, purely combinational.
//   a,b,c,d : signed W-bit inputs
//   o0      : a + b + c      (signed W+2 bits)
//   o1      : b - c - d      (signed W+2 bits)
// Two extra bits cover the worst case of three full-scale operands.
// ---------------------------------------------------------------------------
module winograd_at_1d #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] o0,
  output logic signed [W+1:0] o1
);

  logic signed [W+1:0] a_x, b_x, c_x, d_x;

  // Sign-extend before summing so no partial result can wrap.
  assign a_x = {{2{a[W-1]}}, a};
  assign b_x = {{2{b[W-1]}}, b};
  assign c_x = {{2{c[W-1]}}, c};
  assign d_x = {{2{d[W-1]}}, d};

  assign o0 = a_x + b_x + c_x;
  assign o1 = b_x - c_x - d_x;

endmodule

// File: rtl/winograd_output_transform.sv
// ---------------------------------------------------------------------------
// winograd_output_transform
// Winograd F(2x2,3x3) output transform Y = A^T * M * A as a two-stage
// valid/ready pipeline, one tile per cycle when unstalled.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of winograd_output_transform_if
//          (in_valid/in_ready/in_tile, out_valid/out_ready/out_tile)
// Stage 1 registers T = A^T*M (2x4, IW+2 bits); stage 2 registers Y = T*A
// (2x2, IW+4 bits) and drives out_tile directly.
// ---------------------------------------------------------------------------
module winograd_output_transform
  import winograd_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  winograd_output_transform_if.slave  bus
);

  localparam int TW = IW + 2;
  localparam int OW = IW + 4;

  logic [TILE_OUT-1:0][TILE_IN-1:0][TW-1:0] t_next;
  logic [TILE_OUT-1:0][TILE_IN-1:0][TW-1:0] s1_t;
  logic [4*OW-1:0]                          y_next;
  logic [4*OW-1:0]                          out_tile_q;
  logic                                     s1_valid;
  logic                                     s2_valid;
  logic                                     adv1;
  logic                                     adv2;

  // Each stage may advance when it is empty or the stage after it is moving.
  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.out_tile  = out_tile_q;

  // Column pass: each column of M collapses to one column of T.
  for (genvar c = 0; c < TILE_IN; c++) begin : g_col
    winograd_at_1d #(.W(IW)) u_col (
      .a  (bus.in_tile[elem_in_msb(0, c, IW) -: IW]),
      .b  (bus.in_tile[elem_in_msb(1, c, IW) -: IW]),
      .c  (bus.in_tile[elem_in_msb(2, c, IW) -: IW]),
      .d  (bus.in_tile[elem_in_msb(3, c, IW) -: IW]),
      .o0 (t_next[0][c]),
      .o1 (t_next[1][c])
    );
  end

  // Row pass: each registered row of T collapses to one row of Y.
  for (genvar i = 0; i < TILE_OUT; i++) begin : g_row
    winograd_at_1d #(.W(TW)) u_row (
      .a  (s1_t[i][0]),
      .b  (s1_t[i][1]),
      .c  (s1_t[i][2]),
      .d  (s1_t[i][3]),
      .o0 (y_next[elem_out_msb(i, 0, OW) -: OW]),
      .o1 (y_next[elem_out_msb(i, 1, OW) -: OW])
    );
  end

  // Pipeline registers. A stage that advances with nothing upstream becomes
  // empty; data registers only load when a real tile moves in, so a held or
  // drained stage keeps its last contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_t       <= '0;
      out_tile_q <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_t <= t_next;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_tile_q <= y_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_output_transform.sv
// ---------------------------------------------------------------------------
// tb_winograd_output_transform
// Directed bench for the Winograd output transform: reset state, three
// hand-computed tiles, a back-to-back stream, a stall, random back-pressure
// against a reference model, and a reset pulse with both stages full.
// ---------------------------------------------------------------------------
module tb_winograd_output_transform;

  localparam int IW = 8;
  localparam int OW = IW + 4;

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;
  logic [4*OW-1:0] exp_q[$];

  winograd_output_transform_if #(.IW(IW)) bus ();

  winograd_output_transform #(.IW(IW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pack 16 integers (row-major, (0,0) first) into an input tile.
  function automatic logic [16*IW-1:0] pack_m(input int m[16]);
    logic [16*IW-1:0] t;
    logic [31:0]      v;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      v = m[k];
      t[(16-k)*IW-1 -: IW] = v[IW-1:0];
    end
    return t;
  endfunction

  function automatic logic [4*OW-1:0] pack_y(input int y0, input int y1, input int y2, input int y3);
    logic [4*OW-1:0] t;
    logic [31:0]     v;
    int              ys[4];
    ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      v = ys[k];
      t[(4-k)*OW-1 -: OW] = v[OW-1:0];
    end
    return t;
  endfunction

  // Reference: full matrix product A^T * M * A in integer arithmetic.
  function automatic logic [4*OW-1:0] model_y(input logic [16*IW-1:0] tile);
    int at [2][4];
    int m  [4][4];
    int t  [2][4];
    int y  [4];
    logic [IW-1:0] e;
    at = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    for (int rr = 0; rr < 4; rr++) begin
      for (int cc = 0; cc < 4; cc++) begin
        e = tile[(16-(rr*4+cc))*IW-1 -: IW];
        m[rr][cc] = int'($signed(e));
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int cc = 0; cc < 4; cc++) begin
        t[i][cc] = 0;
        for (int rr = 0; rr < 4; rr++) t[i][cc] += at[i][rr] * m[rr][cc];
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        y[i*2+j] = 0;
        for (int cc = 0; cc < 4; cc++) y[i*2+j] += t[i][cc] * at[j][cc];
      end
    end
    return pack_y(y[0], y[1], y[2], y[3]);
  endfunction

  function automatic logic [16*IW-1:0] gen_tile(input int k);
    int m[16];
    for (int i = 0; i < 16; i++) m[i] = ((k * 37 + i * 11 + 5) % 256) - 128;
    return pack_m(m);
  endfunction

  task automatic test_reset;
    rstn = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_tile   = '0;
    bus.out_ready = 1'b0;
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    vectors++;
    if (bus.out_tile !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_tile: got %h expected 0", bus.out_tile);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_out_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  // Single tile through an empty pipeline: s1 loads on the accept edge,
  // out_tile on the following edge.
  task automatic test_tile(input string name, input logic [16*IW-1:0] tile,
                           input logic [4*OW-1:0] expy);
    bus.in_valid  = 1'b1;
    bus.in_tile   = tile;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_in_ready: got %b expected 1", name, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_early: got out_valid %b expected 0", name, bus.out_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: got out_valid %b expected 1", name, bus.out_valid);
    end
    vectors++;
    if (bus.out_tile !== expy) begin
      miscompares++;
      $display("[TB] FAIL %s_data: got %h expected %h", name, bus.out_tile, expy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_dup: got out_valid %b expected 0", name, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [16*IW-1:0] tiles[8];
    int got;
    got = 0;
    for (int k = 0; k < 8; k++) tiles[k] = gen_tile(k + 100);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_tile   = tiles[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (cyc < 8) begin
        vectors++;
        if (bus.in_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_in_ready: got %b expected 1 at cycle %0d", bus.in_ready, cyc);
        end
      end
      @(posedge clk);
      #1;
      if (cyc + 1 < 8) bus.in_tile = tiles[cyc+1];
      else bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1 && got < 8) begin
        vectors++;
        if (bus.out_tile !== model_y(tiles[got])) begin
          miscompares++;
          $display("[TB] FAIL b2b_data%0d: got %h expected %h", got, bus.out_tile, model_y(tiles[got]));
        end
        got++;
      end else if (got > 0 && got < 8) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL b2b_bubble: got out_valid %b expected 1 after %0d results", bus.out_valid, got);
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d expected 8", got);
    end
  endtask

  task automatic test_stall;
    logic [16*IW-1:0] ta, tb, tc;
    ta = gen_tile(7);
    tb = gen_tile(8);
    tc = gen_tile(9);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tile   = ta;
    @(posedge clk);
    #1;
    bus.in_tile = tb;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_fill_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_tile = tc;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_full_ready: got %b expected 0", bus.in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_tile !== model_y(ta) || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got v=%b r=%b %h expected v=1 r=0 %h",
                 k, bus.out_valid, bus.in_ready, bus.out_tile, model_y(ta));
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_tile !== model_y(tb)) begin
      miscompares++;
      $display("[TB] FAIL stall_second: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_tile, model_y(tb));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_tile !== model_y(tc)) begin
      miscompares++;
      $display("[TB] FAIL stall_third: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_tile, model_y(tc));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  // Random out_ready with a scoreboard: expected results are queued at
  // accept and popped at each output transfer.
  task automatic test_random_backpressure;
    int n_tiles, sent, received, cyc;
    logic acc, deq, stalled;
    logic [4*OW-1:0] held, expy;
    n_tiles  = 20;
    sent     = 0;
    received = 0;
    cyc      = 0;
    exp_q.delete();
    bus.in_valid = 1'b1;
    bus.in_tile  = gen_tile(200);
    while (received < n_tiles && cyc < 400) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc     = bus.in_valid && bus.in_ready;
      deq     = bus.out_valid && bus.out_ready;
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_tile;
      if (deq) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rand_spurious: got %h expected no output", bus.out_tile);
        end else begin
          expy = exp_q.pop_front();
          if (bus.out_tile !== expy) begin
            miscompares++;
            $display("[TB] FAIL rand_data%0d: got %h expected %h", received, bus.out_tile, expy);
          end
        end
        received++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(model_y(bus.in_tile));
        sent++;
        if (sent < n_tiles) bus.in_tile = gen_tile(200 + sent);
        else bus.in_valid = 1'b0;
      end
      if (stalled) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_tile !== held) begin
          miscompares++;
          $display("[TB] FAIL rand_hold: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_tile, held);
        end
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (received != n_tiles || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rand_count: got %0d results (%0d pending) expected %0d", received, exp_q.size(), n_tiles);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight;
    logic [16*IW-1:0] tn;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tile   = gen_tile(50);
    @(posedge clk);
    #1;
    bus.in_tile = gen_tile(51);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_prefill: got out_valid %b expected 1", bus.out_valid);
    end
    #1 rstn = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus.out_valid);
    end
    vectors++;
    if (bus.out_tile !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_out_tile: got %h expected 0", bus.out_tile);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk) rstn = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_discard: got out_valid %b expected 0", bus.out_valid);
    end
    tn = gen_tile(52);
    test_tile("post_reset", tn, model_y(tn));
  endtask

  initial begin
    int m[16];
    test_reset();

    for (int k = 0; k < 16; k++) m[k] = 1;
    test_tile("ones", pack_m(m), pack_y(9, -3, -3, 1));

    for (int k = 0; k < 16; k++) m[k] = k;
    test_tile("ramp", pack_m(m), pack_y(45, -24, -51, 20));

    for (int k = 0; k < 16; k++) m[k] = -128;
    test_tile("minval", pack_m(m), pack_y(-1152, 384, 384, -128));

    test_back_to_back();
    test_stall();
    test_random_backpressure();
    test_reset_midflight();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
